// File: rtl/ipu_merge_slicer_pkg.sv
// Shared FSM type, default sizing and select range helper for the merge/slice path.
package ipu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IN = 2'd1,
    SEND    = 2'd2
  } ipu_state_e;

  localparam int IPU_WIDTH  = 11;
  localparam int IPU_ADDR_W = 4;
  localparam int IPU_N_IN   = 3;

  // A select token names a real source only when it is below the source count.
  function automatic logic sel_in_range(input int sel, input int n_in);
    return (sel < n_in);
  endfunction

endpackage

// File: rtl/ipu_merge_slicer_fork_reg.sv
// Two-way registered fork: holds a data field and an address field, each valid
// clearing on its own handshake; done flags the edge that empties the pair.
module ipu_fork_reg #(
  parameter int DAT_W  = 7,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DAT_W-1:0]  load_dat,
  input  logic [ADDR_W-1:0] load_addr,
  output logic              dat_valid,
  input  logic              dat_ready,
  output logic [DAT_W-1:0]  dat_data,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr_data,
  output logic              done
);

  logic              dat_valid_reg;
  logic              addr_valid_reg;
  logic [DAT_W-1:0]  dat_data_reg;
  logic [ADDR_W-1:0] addr_data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      dat_valid_reg  <= 1'b0;
      addr_valid_reg <= 1'b0;
      dat_data_reg   <= '0;
      addr_data_reg  <= '0;
    end else if (load) begin
      dat_valid_reg  <= 1'b1;
      addr_valid_reg <= 1'b1;
      dat_data_reg   <= load_dat;
      addr_data_reg  <= load_addr;
    end else begin
      if (dat_valid_reg && dat_ready) begin
        dat_valid_reg <= 1'b0;
      end
      if (addr_valid_reg && addr_ready) begin
        addr_valid_reg <= 1'b0;
      end
    end
  end

  // High on the edge where every still-pending field is being taken.
  assign done = (dat_valid_reg | addr_valid_reg)
              & (~dat_valid_reg  | dat_ready)
              & (~addr_valid_reg | addr_ready);

  assign dat_valid  = dat_valid_reg;
  assign addr_valid = addr_valid_reg;
  assign dat_data   = dat_data_reg;
  assign addr_data  = addr_data_reg;

endmodule

// File: rtl/ipu_merge_slicer.sv
// Select-driven merge of N_IN sources, splitting each word into data/address fields.
// Optional IPU_SEL_ERR_EN adds sel_err_cnt, a saturating count of dropped selects.
module ipu_merge_slicer
  import ipu_pkg::*;
#(
  parameter int N_IN   = IPU_N_IN,
  parameter int WIDTH  = IPU_WIDTH,
  parameter int ADDR_W = IPU_ADDR_W,
  parameter int SEL_W  = $clog2(N_IN),
  parameter int ERR_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sel_valid,
  output logic                    sel_ready,
  input  logic [SEL_W-1:0]        sel_data,
  input  logic [N_IN-1:0]         in_valid,
  output logic [N_IN-1:0]         in_ready,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  output logic                    dat_valid,
  input  logic                    dat_ready,
  output logic [WIDTH-ADDR_W-1:0] dat_data,
  output logic                    addr_valid,
  input  logic                    addr_ready,
  output logic [ADDR_W-1:0]       addr_data,
  output logic                    busy
`ifdef IPU_SEL_ERR_EN
  ,
  output logic [ERR_W-1:0]        sel_err_cnt
`endif
);

  localparam int DAT_W = WIDTH - ADDR_W;

  ipu_state_e       state_reg;
  logic             sel_ready_reg;
  logic [N_IN-1:0]  in_ready_reg;
  logic [N_IN-1:0]  sel_onehot;
  logic [WIDTH-1:0] in_words     [N_IN];
  logic [WIDTH-1:0] masked_words [N_IN];
  logic [WIDTH-1:0] sel_word;
  logic             sel_fire;
  logic             sel_ok;
  logic             in_fire;
  logic             fork_done;

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_src
      assign in_words[gi]     = in_data[gi*WIDTH +: WIDTH];
      assign sel_onehot[gi]   = (sel_data == SEL_W'(gi));
      // The latched one-hot ready doubles as the word mux select.
      assign masked_words[gi] = in_ready_reg[gi] ? in_words[gi] : '0;
    end
  endgenerate

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N_IN; i++) begin
      sel_word = sel_word | masked_words[i];
    end
  end

  assign sel_fire = sel_valid & sel_ready_reg;
  assign sel_ok   = sel_in_range(int'(sel_data), N_IN);
  assign in_fire  = |(in_valid & in_ready_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      sel_ready_reg <= 1'b0;
      in_ready_reg  <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          // Also raises sel_ready on the first cycle after reset.
          sel_ready_reg <= 1'b1;
          if (sel_fire && sel_ok) begin
            sel_ready_reg <= 1'b0;
            in_ready_reg  <= sel_onehot;
            state_reg     <= WAIT_IN;
          end
        end
        WAIT_IN: begin
          if (in_fire) begin
            in_ready_reg <= '0;
            state_reg    <= SEND;
          end
        end
        SEND: begin
          if (fork_done) begin
            sel_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          sel_ready_reg <= 1'b0;
          in_ready_reg  <= '0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  ipu_fork_reg #(
    .DAT_W  (DAT_W),
    .ADDR_W (ADDR_W)
  ) u_fork (
    .clk        (clk),
    .rst        (rst),
    .load       (in_fire),
    .load_dat   (sel_word[WIDTH-1:ADDR_W]),
    .load_addr  (sel_word[ADDR_W-1:0]),
    .dat_valid  (dat_valid),
    .dat_ready  (dat_ready),
    .dat_data   (dat_data),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr_data  (addr_data),
    .done       (fork_done)
  );

  assign sel_ready = sel_ready_reg;
  assign in_ready  = in_ready_reg;
  assign busy      = (state_reg != IDLE);

`ifdef IPU_SEL_ERR_EN
  logic [ERR_W-1:0] sel_err_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_cnt_reg <= '0;
    end else if (sel_fire && !sel_ok && !(&sel_err_cnt_reg)) begin
      sel_err_cnt_reg <= sel_err_cnt_reg + 1'b1;
    end
  end

  assign sel_err_cnt = sel_err_cnt_reg;
`endif

endmodule

// File: tb/tb_ipu_merge_slicer.sv
// Bench for ipu_merge_slicer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, a second wide instance, random traffic.
module tb_ipu_merge_slicer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel_valid;
  logic        sel_ready;
  logic [1:0]  sel_data;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [32:0] in_data;
  logic        dat_valid;
  logic        dat_ready;
  logic [6:0]  dat_data;
  logic        addr_valid;
  logic        addr_ready;
  logic [3:0]  addr_data;
  logic        busy;

  logic        sel2_valid;
  logic        sel2_ready;
  logic [2:0]  sel2_data;
  logic [4:0]  in2_valid;
  logic [4:0]  in2_ready;
  logic [79:0] in2_data;
  logic        dat2_valid;
  logic        dat2_ready;
  logic [9:0]  dat2_data;
  logic        addr2_valid;
  logic        addr2_ready;
  logic [5:0]  addr2_data;
  logic        busy2;

`ifdef IPU_SEL_ERR_EN
  logic [7:0]  sel_err_cnt;
  logic [7:0]  sel_err_cnt2;
  int          err_model;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          pend_sel [$];
  logic [6:0]  exp_dat  [$];
  logic [3:0]  exp_addr [$];
  logic        last_rst = 1'b1;
  logic        sel_took;
  logic [2:0]  in_took;
  int          dat_count = 0;

  // Random stimulus state
  int          sel_list [$];
  logic [10:0] src_q    [3][$];

  always #5 clk = ~clk;

  ipu_merge_slicer dut (
    .clk        (clk),
    .rst        (rst),
    .sel_valid  (sel_valid),
    .sel_ready  (sel_ready),
    .sel_data   (sel_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .dat_valid  (dat_valid),
    .dat_ready  (dat_ready),
    .dat_data   (dat_data),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr_data  (addr_data),
    .busy       (busy)
`ifdef IPU_SEL_ERR_EN
    ,
    .sel_err_cnt(sel_err_cnt)
`endif
  );

  ipu_merge_slicer #(
    .N_IN   (5),
    .WIDTH  (16),
    .ADDR_W (6)
  ) dut2 (
    .clk        (clk),
    .rst        (rst),
    .sel_valid  (sel2_valid),
    .sel_ready  (sel2_ready),
    .sel_data   (sel2_data),
    .in_valid   (in2_valid),
    .in_ready   (in2_ready),
    .in_data    (in2_data),
    .dat_valid  (dat2_valid),
    .dat_ready  (dat2_ready),
    .dat_data   (dat2_data),
    .addr_valid (addr2_valid),
    .addr_ready (addr2_ready),
    .addr_data  (addr2_data),
    .busy       (busy2)
`ifdef IPU_SEL_ERR_EN
    ,
    .sel_err_cnt(sel_err_cnt2)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) last_rst <= rst;

  // Compare process: outputs must follow from the queues of accepted selects and words.
  always @(negedge clk) begin
    int         inflight;
    logic [2:0] exp_ir;
    logic [10:0] word;
    if (rst) begin
      pend_sel.delete();
      exp_dat.delete();
      exp_addr.delete();
      sel_took = 1'b0;
      in_took  = 3'b000;
`ifdef IPU_SEL_ERR_EN
      err_model = 0;
`endif
    end else if (last_rst) begin
      check("rst_sel_ready",  32'(sel_ready),  32'd0);
      check("rst_in_ready",   32'(in_ready),   32'd0);
      check("rst_dat_valid",  32'(dat_valid),  32'd0);
      check("rst_addr_valid", 32'(addr_valid), 32'd0);
      check("rst_dat_data",   32'(dat_data),   32'd0);
      check("rst_addr_data",  32'(addr_data),  32'd0);
      check("rst_busy",       32'(busy),       32'd0);
`ifdef IPU_SEL_ERR_EN
      check("rst_err_cnt",    32'(sel_err_cnt), 32'd0);
`endif
      sel_took = 1'b0;
      in_took  = 3'b000;
    end else begin
      inflight = pend_sel.size() + ((exp_dat.size() != 0 || exp_addr.size() != 0) ? 1 : 0);
      exp_ir   = (pend_sel.size() != 0) ? 3'(1 << pend_sel[0]) : 3'b000;
      check("sel_ready",  32'(sel_ready),  32'(inflight == 0));
      check("busy",       32'(busy),       32'(inflight != 0));
      check("in_ready",   32'(in_ready),   32'(exp_ir));
      check("dat_valid",  32'(dat_valid),  32'(exp_dat.size() != 0));
      check("addr_valid", 32'(addr_valid), 32'(exp_addr.size() != 0));
      if (dat_valid && exp_dat.size() != 0)
        check("dat_data", 32'(dat_data), 32'(exp_dat[0]));
      if (addr_valid && exp_addr.size() != 0)
        check("addr_data", 32'(addr_data), 32'(exp_addr[0]));
`ifdef IPU_SEL_ERR_EN
      check("err_cnt", 32'(sel_err_cnt), 32'(err_model));
`endif
      // Handshakes completing at the coming edge
      if (dat_valid && dat_ready && exp_dat.size() != 0) begin
        void'(exp_dat.pop_front());
        dat_count++;
      end
      if (addr_valid && addr_ready && exp_addr.size() != 0)
        void'(exp_addr.pop_front());
      in_took = in_valid & in_ready;
      for (int i = 0; i < 3; i++) begin
        if (in_took[i]) begin
          word = in_data[i*11 +: 11];
          check("in_source", 32'(i), (pend_sel.size() != 0) ? 32'(pend_sel[0]) : 32'hFFFF_FFFF);
          if (pend_sel.size() != 0) void'(pend_sel.pop_front());
          exp_dat.push_back(7'(word / 16));
          exp_addr.push_back(4'(word % 16));
        end
      end
      sel_took = sel_valid && sel_ready;
      if (sel_took) begin
        if (int'(sel_data) < 3) pend_sel.push_back(int'(sel_data));
`ifdef IPU_SEL_ERR_EN
        else if (err_model < 255) err_model++;
`endif
      end
    end
  end

  initial begin
    int total;
    int base;
    int cyc;
    int s;
    rst        = 1'b1;
    sel_valid  = 1'b0;
    sel_data   = 2'd0;
    in_valid   = 3'b000;
    in_data    = '0;
    dat_ready  = 1'b0;
    addr_ready = 1'b0;
    sel2_valid = 1'b0;
    sel2_data  = 3'd0;
    in2_valid  = 5'b00000;
    in2_data   = '0;
    dat2_ready = 1'b1;
    addr2_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_sel_ready", 32'(sel_ready), 32'd0);
    tick();
    @(negedge clk);
    check("sel_ready_rise", 32'(sel_ready), 32'd1);

    // Basic word: source 1, 11'h5A3 -> dat 7'h5A, addr 4'h3
    tick();
    sel_valid = 1'b1; sel_data = 2'd1; in_valid = 3'b111;
    in_data = {11'h222, 11'h5A3, 11'h111}; dat_ready = 1'b1; addr_ready = 1'b1;
    @(negedge clk);
    check("t1_sel_ready", 32'(sel_ready), 32'd1);
    tick();
    sel_valid = 1'b0;
    @(negedge clk);
    check("t1_in_ready", 32'(in_ready), 32'b010);
    check("t1_dat_valid_early", 32'(dat_valid), 32'd0);
    tick();
    in_valid = 3'b000;
    @(negedge clk);
    check("t1_dat_valid", 32'(dat_valid), 32'd1);
    check("t1_addr_valid", 32'(addr_valid), 32'd1);
    check("t1_dat_data", 32'(dat_data), 32'h5A);
    check("t1_addr_data", 32'(addr_data), 32'h3);
    check("t1_in_ready_off", 32'(in_ready), 32'd0);
    tick();
    @(negedge clk);
    check("t1_done_valid", 32'(dat_valid), 32'd0);
    check("t1_done_sel_ready", 32'(sel_ready), 32'd1);

    // Out-of-range select is consumed and dropped
    tick();
    sel_valid = 1'b1; sel_data = 2'd3;
    tick();
    sel_valid = 1'b0;
    @(negedge clk);
    check("t2_in_ready", 32'(in_ready), 32'd0);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_sel_ready", 32'(sel_ready), 32'd1);
`ifdef IPU_SEL_ERR_EN
    check("t2_err_one", 32'(sel_err_cnt), 32'd1);
`endif
    tick();
    sel_valid = 1'b1;
    repeat (299) tick();
    sel_valid = 1'b0;
    @(negedge clk);
    check("t2_busy_after", 32'(busy), 32'd0);
`ifdef IPU_SEL_ERR_EN
    check("t2_err_sat", 32'(sel_err_cnt), 32'd255);
`endif

    // Back-pressure on the data field only: 11'h2C6 -> dat 7'h2C, addr 4'h6
    tick();
    sel_valid = 1'b1; sel_data = 2'd0; in_valid = 3'b001;
    in_data = {22'h0, 11'h2C6}; dat_ready = 1'b0; addr_ready = 1'b1;
    tick();
    sel_valid = 1'b0;
    tick();
    in_valid = 3'b000;
    @(negedge clk);
    check("t3_addr_valid", 32'(addr_valid), 32'd1);
    check("t3_addr_data", 32'(addr_data), 32'h6);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      check("t3_addr_gone", 32'(addr_valid), 32'd0);
      check("t3_dat_hold", 32'(dat_valid), 32'd1);
      check("t3_dat_data", 32'(dat_data), 32'h2C);
      check("t3_sel_blocked", 32'(sel_ready), 32'd0);
    end
    tick();
    dat_ready = 1'b1;
    tick();
    @(negedge clk);
    check("t3_release", 32'(sel_ready), 32'd1);

    // Reset while holding a word in SEND
    tick();
    sel_valid = 1'b1; sel_data = 2'd2; in_valid = 3'b100;
    in_data = {11'h4C7, 22'h0}; dat_ready = 1'b0; addr_ready = 1'b0;
    tick();
    sel_valid = 1'b0;
    tick();
    in_valid = 3'b000;
    @(negedge clk);
    check("t4_in_send", 32'(busy), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t4_rst_dat_valid", 32'(dat_valid), 32'd0);
    check("t4_rst_addr_valid", 32'(addr_valid), 32'd0);
    check("t4_rst_dat_data", 32'(dat_data), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    tick();
    @(negedge clk);
    check("t4_sel_ready", 32'(sel_ready), 32'd1);
    tick();
    sel_valid = 1'b1; sel_data = 2'd2; in_valid = 3'b100;
    in_data = {11'h123, 22'h0}; dat_ready = 1'b1; addr_ready = 1'b1;
    tick();
    sel_valid = 1'b0;
    tick();
    in_valid = 3'b000;
    @(negedge clk);
    check("t4_dat_data", 32'(dat_data), 32'h12);
    check("t4_addr_data", 32'(addr_data), 32'h3);
    tick();

    // Wide instance: source 4 word 16'hBEEF -> addr 6'h2F, dat 10'h2FB
    tick();
    sel2_valid = 1'b1; sel2_data = 3'd4; in2_valid = 5'b10000; in2_data = {16'hBEEF, 64'h0};
    tick();
    sel2_valid = 1'b0;
    @(negedge clk);
    check("t6_in_ready", 32'(in2_ready), 32'b10000);
    tick();
    in2_valid = 5'b00000;
    @(negedge clk);
    check("t6_dat_valid", 32'(dat2_valid), 32'd1);
    check("t6_dat_data", 32'(dat2_data), 32'h2FB);
    check("t6_addr_data", 32'(addr2_data), 32'h2F);
    tick();

    // Random traffic: every generated word must come out once, in per-source order
    sel_valid = 1'b0; in_valid = 3'b000;
    tick();
    tick();
    total = 2500;
    for (int n = 0; n < total; n++) begin
      s = $urandom_range(0, 2);
      src_q[s].push_back(11'($urandom_range(0, 2047)));
      if ($urandom_range(0, 15) == 0) sel_list.push_back(3);
      sel_list.push_back(s);
    end
    base = dat_count;
    cyc  = 0;
    while ((sel_list.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0 ||
            src_q[2].size() != 0 || pend_sel.size() != 0 || exp_dat.size() != 0 ||
            exp_addr.size() != 0) && cyc < 40000) begin
      if (sel_took && sel_list.size() != 0) void'(sel_list.pop_front());
      for (int i = 0; i < 3; i++)
        if (in_took[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      sel_valid = (sel_list.size() != 0) && ($urandom_range(0, 3) != 0);
      sel_data  = (sel_list.size() != 0) ? 2'(sel_list[0]) : 2'd0;
      for (int i = 0; i < 3; i++) begin
        in_valid[i] = (src_q[i].size() != 0) && ($urandom_range(0, 3) != 0);
        in_data[i*11 +: 11] = (src_q[i].size() != 0) ? src_q[i][0] : 11'h0;
      end
      dat_ready  = ($urandom_range(0, 3) != 0);
      addr_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    sel_valid = 1'b0; in_valid = 3'b000;
    check("rand_in_time", 32'(cyc < 40000), 32'd1);
    check("rand_words", 32'(dat_count - base), 32'(total));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
